// File: rtl/sar_search4.sv
// Successive-approximation search of a WIDTH-bit target through an external magnitude comparator.
// Optional macro SAR_EARLY_EXIT_EN: finish as soon as the comparator reports equality.
module sar_search4 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {S_IDLE, S_SEARCH} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_probe;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic [2:0]       w_resp;
  logic             w_onehot;
  logic             w_early;
  logic [WIDTH-1:0] w_decided;
  logic [WIDTH-1:0] w_next_probe;

  assign w_resp   = {cmp_eq, cmp_gt, cmp_lt};
  assign w_onehot = (w_resp == 3'b100) || (w_resp == 3'b010) || (w_resp == 3'b001);

`ifdef SAR_EARLY_EXIT_EN
  assign w_early = cmp_eq;
`else
  assign w_early = 1'b0;
`endif

  // Current bit is kept on gt/eq and cleared on lt; the next lower bit becomes the trial bit.
  assign w_decided    = r_probe & ~(WIDTH'(cmp_lt) << r_idx);
  assign w_next_probe = w_decided | (WIDTH'(1) << (r_idx - IDX_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_probe  <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_probe <= WIDTH'(1) << (WIDTH - 1);
            r_idx   <= IDX_W'(WIDTH - 1);
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (!w_onehot) begin
            r_result <= '0;
            r_err    <= 1'b1;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else if (w_early) begin
            r_result <= r_probe;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else if (r_idx == '0) begin
            r_result <= w_decided;
            r_probe  <= w_decided;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_probe <= w_next_probe;
            r_idx   <= r_idx - IDX_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign probe  = r_probe;
  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;
  assign result = r_result;

endmodule

// File: tb/tb_sar_search4.sv
// Bench for sar_search4: arithmetic search model checked every cycle, plus directed literal checks.
module tb_sar_search4;

  localparam int unsigned WIDTH = 4;
  typedef logic [3:0] pv_t [4];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cmp_eq, cmp_gt, cmp_lt;
  logic [3:0] probe, result;
  logic       busy, done, err;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] target = 4'd0;
  logic       fault = 1'b0;
  bit         cmp_en = 1'b0;

  sar_search4 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
    .probe(probe), .busy(busy), .done(done), .err(err), .result(result)
  );

  always #5 clk = ~clk;

  // Comparator a=target, b=probe; fault forces an illegal eq+lt response.
  function automatic logic [2:0] resp(input logic [3:0] t, input logic [3:0] p, input logic f);
    if (f) return 3'b101;
    if (t == p) return 3'b100;
    if (t > p) return 3'b010;
    return 3'b001;
  endfunction

  assign {cmp_eq, cmp_gt, cmp_lt} = resp(target, probe, fault);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: search step k tests bit WIDTH-1-k with the target's higher bits already known.
  bit         m_active = 1'b0;
  int         m_k = 0;
  logic [3:0] m_probe = 4'd0, m_result = 4'd0;
  bit         m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;

  always @(posedge clk) begin
    logic [2:0] r;
    int idx;
    int t;
    r = resp(target, m_probe, fault);
    t = int'(target);
    if (rst) begin
      m_active = 0; m_k = 0; m_probe = 0; m_result = 0;
      m_busy = 0; m_done = 0; m_err = 0;
    end else begin
      m_done = 0;
      if (!m_active) begin
        if (start) begin
          m_active = 1; m_k = 0; m_err = 0; m_busy = 1;
          m_probe = 4'(2 ** (WIDTH - 1));
        end
      end else begin
        idx = WIDTH - 1 - m_k;
        if ($countones(r) != 1) begin
          m_result = 0; m_err = 1; m_done = 1; m_busy = 0; m_active = 0;
        end
`ifdef SAR_EARLY_EXIT_EN
        else if (r == 3'b100) begin
          m_result = m_probe; m_done = 1; m_busy = 0; m_active = 0;
        end
`endif
        else if (idx == 0) begin
          m_result = target; m_probe = target; m_done = 1; m_busy = 0; m_active = 0;
        end else begin
          m_probe = 4'((t / (2 ** idx)) * (2 ** idx) + 2 ** (idx - 1));
          m_k++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_probe", probe, m_probe);
      check("model_busy", busy, m_busy);
      check("model_done", done, m_done);
      check("model_err", err, m_err);
      check("model_result", result, m_result);
    end
  end

  // One start pulse; returns after done with latency counted from the accepting cycle.
  task automatic run_search(input logic [3:0] t, input int exp_lat, input pv_t ep, input int np);
    pv_t rec;
    int  n = 0;
    int  cyc;
    target = t;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    cyc = 1;
    while (!done && cyc < 20) begin
      if (busy && n < 4) begin rec[n] = probe; n++; end
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, exp_lat);
    check("result", result, t);
    check("err_clear", err, 0);
    check("probe_count", n, np);
    for (int i = 0; i < np && i < n; i++) check("probe_seq", rec[i], ep[i]);
  endtask

  initial begin
    int cyc;
    int ndone;
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int ndone;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_probe", probe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_result", result, 0);
    cmp_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    run_search(4'd5,  5, '{4'd8, 4'd4,  4'd6,  4'd5},  4);
    run_search(4'd0,  5, '{4'd8, 4'd4,  4'd2,  4'd1},  4);
    run_search(4'd15, 5, '{4'd8, 4'd12, 4'd14, 4'd15}, 4);
`ifdef SAR_EARLY_EXIT_EN
    run_search(4'd8,  2, '{4'd8, 4'd0,  4'd0,  4'd0},  1);
`else
    run_search(4'd8,  5, '{4'd8, 4'd12, 4'd10, 4'd9},  4);
`endif

    // Illegal eq+lt response on the second decision.
    target = 4'd9;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 fault = 1'b1;
    @(posedge clk); #1 fault = 1'b0;
    @(negedge clk);
    check("perr_done", done, 1);
    check("perr_err", err, 1);
    check("perr_result", result, 0);
    check("perr_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("perr_sticky", err, 1);
    check("perr_done_width", done, 0);
    run_search(4'd11, 5, '{4'd8, 4'd12, 4'd10, 4'd11}, 4);

    // Reset during the second search cycle.
    target = 4'd7;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mrst_probe", probe, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_result", result, 0);
    @(posedge clk); #1 rst = 1'b0;
    ndone = 0;
    repeat (8) begin @(negedge clk); if (done) ndone++; end
    check("mrst_no_done", ndone, 0);
    run_search(4'd7, 5, '{4'd8, 4'd4, 4'd6, 4'd7}, 4);

    // Start pulsed while busy is ignored.
    target = 4'd3;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    cyc = 3;
    while (!done && cyc < 20) begin @(negedge clk); cyc++; end
    check("busy_start_latency", cyc, 5);
    check("busy_start_result", result, 3);

    // Start held high gives back-to-back searches.
    target = 4'd13;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk);
    ndone = 0;
    repeat (12) begin @(negedge clk); if (done) ndone++; end
    check("held_start_dones", ndone, 2);
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin @(negedge clk); cyc++; end
    check("held_start_last_done", done, 1);
    check("held_start_result", result, 13);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
